// File: rtl/lbm_step_sequencer.sv
// Step controller for the Lattice Boltzmann engine: initialises the lattice, streams every
// cell through the collider in place, then hands the BRAM to the streamer once per step.
module lbm_step_sequencer #(
  parameter int NUM_CELLS  = 31570,
  parameter int Q          = 9,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int INIT_REST  = 10,
  parameter int INIT_FLOW  = 127,
  parameter int INIT_BG    = 15,
  parameter int EAST_INDEX = 3,
  localparam int ADDR_WIDTH = $clog2(NUM_CELLS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [1:0]                 init_sel_in,
  input  logic [1:0]                 run_mode_in,
  input  logic [15:0]                steps_in,
  input  logic                       btn_in,
  output logic [ADDR_WIDTH-1:0]      rd_addr_out,
  output logic                       rd_en_out,
  input  logic [Q*DATA_WIDTH-1:0]    rd_data_in,
  output logic [ADDR_WIDTH-1:0]      wr_addr_out,
  output logic [Q*DATA_WIDTH-1:0]    wr_data_out,
  output logic                       wr_en_out,
  output logic                       col_valid_out,
  output logic [Q*DATA_WIDTH-1:0]    col_data_out,
  input  logic                       col_valid_in,
  input  logic [Q*DATA_WIDTH-1:0]    col_data_in,
  output logic                       stream_start_out,
  input  logic                       stream_done_in,
  output logic                       stream_active_out,
  output logic [15:0]                step_count_out,
  output logic [1:0]                 state_out
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CELLS - 1);
  localparam logic [CNT_W-1:0]      CELL_CNT  = CNT_W'(NUM_CELLS);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL   = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    ST_SETUP   = 2'd0,
    ST_COLLIDE = 2'd1,
    ST_STREAM  = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t                  state;
  logic [RD_LATENCY-1:0]   valid_pipe;
  logic [CNT_W-1:0]        wr_cnt;
  logic [15:0]             remaining;
  logic                    btn_prev;

  function automatic logic [Q*DATA_WIDTH-1:0] init_word(input logic [1:0] sel);
    logic [Q*DATA_WIDTH-1:0] w;
    w = '0;
    for (int d = 0; d < Q; d++) begin
      case (sel)
        2'd0:    w[d*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(INIT_REST);
        2'd1:    w[d*DATA_WIDTH +: DATA_WIDTH] = (d == EAST_INDEX) ? DATA_WIDTH'(INIT_FLOW)
                                                                   : DATA_WIDTH'(INIT_BG);
        2'd2:    w[d*DATA_WIDTH +: DATA_WIDTH] = '0;
        default: w[d*DATA_WIDTH +: DATA_WIDTH] = MAX_VAL;
      endcase
    end
    return w;
  endfunction

  // Read data returns RD_LATENCY cycles after the enable, so the enable is delayed to match.
  // NOTE: the pipe is cleared on reset so reads in flight at reset never reach the collider.
  always_ff @(posedge clk_in) begin
    if (rst_in) valid_pipe <= '0;
    else        valid_pipe <= RD_LATENCY'({valid_pipe, rd_en_out});
  end

  assign col_valid_out = valid_pipe[RD_LATENCY-1];
  assign col_data_out  = rd_data_in;
  assign state_out     = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= ST_SETUP;
      rd_addr_out       <= '0;
      rd_en_out         <= 1'b0;
      wr_addr_out       <= '0;
      wr_data_out       <= '0;
      wr_en_out         <= 1'b0;
      stream_start_out  <= 1'b0;
      stream_active_out <= 1'b0;
      step_count_out    <= '0;
      wr_cnt            <= '0;
      remaining         <= '0;
      btn_prev          <= 1'b0;
    end else begin
      btn_prev <= btn_in;
      // NOTE: pulse-style outputs default low every cycle; branches below raise them for one cycle.
      wr_en_out        <= 1'b0;
      stream_start_out <= 1'b0;

      case (state)
        ST_SETUP: begin
          if (wr_en_out && wr_addr_out == LAST_ADDR) begin
            state       <= ST_COLLIDE;
            rd_en_out   <= 1'b1;
            rd_addr_out <= '0;
            wr_cnt      <= '0;
          end else begin
            wr_en_out   <= 1'b1;
            wr_addr_out <= wr_en_out ? wr_addr_out + ADDR_WIDTH'(1) : '0;
            wr_data_out <= init_word(init_sel_in);
          end
        end

        ST_COLLIDE: begin
          if (rd_en_out) begin
            if (rd_addr_out == LAST_ADDR) rd_en_out   <= 1'b0;
            else                          rd_addr_out <= rd_addr_out + ADDR_WIDTH'(1);
          end
          // Writes trail reads in address order, so updating in place is safe.
          if (col_valid_in && wr_cnt != CELL_CNT) begin
            wr_en_out   <= 1'b1;
            wr_addr_out <= wr_cnt[ADDR_WIDTH-1:0];
            wr_data_out <= col_data_in;
            wr_cnt      <= wr_cnt + CNT_W'(1);
          end
          if (wr_en_out && wr_addr_out == LAST_ADDR) begin
            state             <= ST_STREAM;
            stream_start_out  <= 1'b1;
            stream_active_out <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (stream_done_in && !stream_start_out) begin
            step_count_out    <= step_count_out + 16'd1;
            stream_active_out <= 1'b0;
            state             <= ST_WAIT;
            case (run_mode_in)
              2'd1: begin
                state       <= ST_COLLIDE;
                rd_en_out   <= 1'b1;
                rd_addr_out <= '0;
                wr_cnt      <= '0;
              end
              2'd2: begin
                if (remaining > 16'd1) begin
                  remaining   <= remaining - 16'd1;
                  state       <= ST_COLLIDE;
                  rd_en_out   <= 1'b1;
                  rd_addr_out <= '0;
                  wr_cnt      <= '0;
                end else begin
                  remaining <= '0;
                end
              end
              default: ;
            endcase
          end
        end

        ST_WAIT: begin
          if (btn_in && !btn_prev) begin
            state       <= ST_COLLIDE;
            rd_en_out   <= 1'b1;
            rd_addr_out <= '0;
            wr_cnt      <= '0;
            if (run_mode_in == 2'd2) remaining <= (steps_in == 16'd0) ? 16'd1 : steps_in;
          end
        end

        default: state <= ST_SETUP;
      endcase
    end
  end

endmodule

// File: doc/lbm_step_sequencer.md
Name: lbm_step_sequencer

Overview:
- Parametrised next-generation controller for the Lattice Boltzmann engine.
- Sequences SETUP (lattice initialisation) → COLLIDE (fully pipelined, one cell per cycle) → STREAM (hands off to external streamer) → WAIT.
- Adds configurable lattice size, direction count, data width and BRAM read latency, plus single-step, free-run and N-step run modes.
- Sits between the distribution BRAM bank, the collision unit and the streaming unit. The top level muxes BRAM ports to the streamer while stream_active_out is high.

Parameters:
NUM_CELLS, 31570, lattice points; ADDR_WIDTH = $clog2(NUM_CELLS) (derived localparam)
Q, 9, directions per cell; order is center, N, NE, E, SE, S, SW, W, NW
DATA_WIDTH, 8, bits per distribution value
RD_LATENCY, 2, BRAM read latency in cycles (≥1)
INIT_REST, 10, value written to every direction when init_sel_in = 0
INIT_FLOW, 127, value written to direction EAST_INDEX when init_sel_in = 1
INIT_BG, 15, value written to all other directions when init_sel_in = 1
EAST_INDEX, 3, direction index that receives INIT_FLOW

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous, active-high reset
init_sel_in  input  2  init pattern: 0 rest, 1 east flow, 2 all zero, 3 all max (2^(DATA_WIDTH-1)-1)
run_mode_in  input  2  0 single-step, 1 free-run, 2 N-step, 3 treated as 0
steps_in  input  16  step count for N-step mode
btn_in  input  1  step/run trigger, already debounced
rd_addr_out  output  ADDR_WIDTH  BRAM read address
rd_en_out  output  1  BRAM read enable
rd_data_in  input  Q*DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after rd_en_out
wr_addr_out  output  ADDR_WIDTH  BRAM write address
wr_data_out  output  Q*DATA_WIDTH  BRAM write data
wr_en_out  output  1  BRAM write enable
col_valid_out  output  1  cell data valid to collider
col_data_out  output  Q*DATA_WIDTH  cell data to collider
col_valid_in  input  1  collided cell valid (in order, any latency)
col_data_in  input  Q*DATA_WIDTH  collided cell data
stream_start_out  output  1  one-cycle start pulse to streamer
stream_done_in  input  1  streamer completion pulse
stream_active_out  output  1  high from the start pulse until done is received
step_count_out  output  16  completed steps since reset; wraps at 2^16
state_out  output  2  0 SETUP, 1 COLLIDE, 2 STREAM, 3 WAIT

Behaviour:
- Reset: state SETUP, all counters 0. All enables, valids and pulses are 0. Addresses, data and step_count_out are 0. Reset mid-operation aborts immediately; no pending pipeline data is written afterwards, because the read-valid pipe is cleared.
- SETUP: wr_en_out=1 for each addr 0..NUM_CELLS-1, one cell per cycle. Data comes from init_sel_in, sampled each cycle. After writing addr NUM_CELLS-1, the next cycle enters COLLIDE with wr_en_out=0.
- COLLIDE read side: rd_en_out=1 for NUM_CELLS consecutive cycles, addr 0..NUM_CELLS-1.
- COLLIDE valid pipe: a RD_LATENCY-deep pipe delays rd_en_out. col_valid_out equals the pipe output. col_data_out = rd_data_in, combinational pass-through.
- COLLIDE write side: each col_valid_in writes col_data_in to wr_addr = write counter, with wr_en_out registered 1 cycle later. The write counter increments on each write.
- In-place hazard: write address is always below the current read address, so no hazard arises. The collider must not reorder.
- COLLIDE exit: the cycle after write NUM_CELLS-1 enters STREAM. stream_start_out=1 for exactly that first STREAM cycle, and stream_active_out=1.
- col_valid_in outside COLLIDE, or beyond NUM_CELLS writes, is ignored.
- STREAM: rd/wr enables are 0. On stream_done_in, step_count_out increments, stream_active_out falls, and the next state is decided:
  - mode 1: COLLIDE.
  - mode 2: COLLIDE while remaining >0 after decrement, else WAIT.
  - modes 0/3: WAIT.
- stream_done_in in any other state is ignored. stream_done_in coincident with the start pulse cycle is ignored.
- WAIT: a btn_in rising edge (btn_in=1, previous sample 0) enters COLLIDE. In mode 2, the same edge loads remaining = steps_in; steps_in=0 is treated as 1.
- Button edges outside WAIT are dropped, not queued. The previous-button register updates every cycle in all states.
- run_mode_in change mid-step takes effect at the next STREAM exit.

Test Plan:
- NUM_CELLS=16, init_sel=1 → 16 writes addr 0..15, each word has [3]=127 and others=15; state goes to COLLIDE the cycle after addr 15.
- Identity collider with 3-cycle latency, RD_LATENCY=2 → reads 0..15 back-to-back; writes land at 0..15 in order; one stream_start_out pulse after the 16th write.
- Mode 0: stream_done → WAIT, step_count=1; btn held high for 5 cycles → exactly one extra step; btn press during COLLIDE → ignored.
- Mode 2, steps_in=3, btn edge → exactly 3 COLLIDE/STREAM cycles, then WAIT, step_count=4; steps_in=0 → 1 step.
- Mode 1 → continuous steps; step_count wraps 65535→0; rst_in asserted mid-COLLIDE → next cycle all outputs 0, state SETUP, no stray wr_en from in-flight reads.
- Spurious col_valid_in in WAIT and stream_done_in in COLLIDE → no write, no state change.
